// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampled, glitch-filtered start detect, LSB-first 5-8 bit frames into a
// show-ahead FIFO with sticky error flags. Define SPART_RX_PARITY_EN to add an even-parity bit.
module spart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OS_RATE    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  input  logic                        sample_en,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [7:0]                  rdata,
  output logic                        rda,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        busy
);
  localparam int unsigned TW = $clog2(OS_RATE);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [TW-1:0] TcntOne  = TW'(1);
  localparam logic [TW-1:0] TcntHalf = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] TcntLast = TW'(OS_RATE - 1);
  localparam logic [2:0]    BcntLast = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [CW-1:0] CntFull  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SPART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e               state_q;
  logic                 sync_q;
  logic                 rxs;
  logic [TW-1:0]        tcnt_q;
  logic [2:0]           bcnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 push_q;
  logic                 fe_set_q;
  logic                 bit_end;
`ifdef SPART_RX_PARITY_EN
  logic                 par_q;
  logic                 pe_set_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs    <= sync_q;
    end
  end

  assign bit_end = (tcnt_q == TcntLast);

  // Receiver FSM; push/error pulses and busy are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      push_q   <= 1'b0;
      fe_set_q <= 1'b0;
      busy     <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_q    <= 1'b0;
      pe_set_q <= 1'b0;
`endif
    end else begin
      push_q   <= 1'b0;
      fe_set_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      pe_set_q <= 1'b0;
`endif
      if (sample_en) begin
        case (state_q)
          StIdle: begin
            if (!rxs) begin
              tcnt_q  <= '0;
              state_q <= StStart;
              busy    <= 1'b1;
            end
          end
          StStart: begin
            if (tcnt_q == TcntHalf) begin
              if (!rxs) begin
                tcnt_q  <= '0;
                bcnt_q  <= '0;
                state_q <= StData;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              tcnt_q <= tcnt_q + TcntOne;
            end
          end
          StData: begin
            if (bit_end) begin
              tcnt_q  <= '0;
              shreg_q <= {rxs, shreg_q[DATA_BITS-1:1]};
              bcnt_q  <= bcnt_q + 3'd1;
              if (bcnt_q == BcntLast) begin
`ifdef SPART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end
            end else begin
              tcnt_q <= tcnt_q + TcntOne;
            end
          end
`ifdef SPART_RX_PARITY_EN
          StParity: begin
            if (bit_end) begin
              tcnt_q  <= '0;
              par_q   <= rxs;
              state_q <= StStop;
            end else begin
              tcnt_q <= tcnt_q + TcntOne;
            end
          end
`endif
          StStop: begin
            if (bit_end) begin
              tcnt_q <= '0;
              if (rxs) begin
                push_q   <= 1'b1;
`ifdef SPART_RX_PARITY_EN
                pe_set_q <= ^{shreg_q, par_q};
`endif
                state_q  <= StIdle;
                busy     <= 1'b0;
              end else begin
                fe_set_q <= 1'b1;
                state_q  <= StBreak;
              end
            end else begin
              tcnt_q <= tcnt_q + TcntOne;
            end
          end
          StBreak: begin
            if (rxs) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // shreg_q is stable in IDLE, so it serves as the write data for the registered push.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        rptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 full;
  logic                 do_pop;
  logic                 do_push;

  assign full    = (cnt_q == CntFull);
  assign rda     = (cnt_q != '0);
  assign do_pop  = rd_en && rda;
  assign do_push = push_q && (!full || do_pop);
  assign count   = cnt_q;
  assign rdata   = rda ? 8'(mem_q[rptr_q]) : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= shreg_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntOne;
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntOne;
    end
  end

  // Set events take priority over clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_q && full && !do_pop) overrun <= 1'b1;
      else if (clr_err)              overrun <= 1'b0;
      if (fe_set_q)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

`ifdef SPART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (push_q && pe_set_q) begin
      parity_err <= 1'b1;
    end else if (clr_err) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo: frame-level reference model plus per-cycle output compare.
module tb_spart_rx_fifo;
`ifdef SPART_RX_PARITY_EN
  localparam int unsigned DB = 7;
  localparam int unsigned PB = 1;
`else
  localparam int unsigned DB = 8;
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned OS    = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  MSK   = 8'((1 << DB) - 1);
  // Clock index (from frame start) whose edge commits the stop-bit push into the FIFO.
  localparam int PUSH_TICK = 3 + OS / 2 + OS * (DB + PB + 1);
  localparam int NOLIMIT   = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       sample_en;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rdata;
  logic       rda;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  always #5 clk = ~clk;

  spart_rx_fifo #(
    .DATA_BITS  (DB),
    .OS_RATE    (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .sample_en  (sample_en),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rdata      (rdata),
    .rda        (rda),
    .count      (count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;
  bit         m_fe  = 1'b0;
  bit         m_pe  = 1'b0;
  bit         chk_en = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rda",   32'(rda),        32'(mq.size() != 0));
      check("cmp_count", 32'(count),      32'(mq.size()));
      check("cmp_rdata", 32'(rdata),      32'((mq.size() != 0) ? mq[0] : 8'h00));
      check("cmp_ovr",   32'(overrun),    32'(m_ovr));
      check("cmp_fe",    32'(frame_err),  32'(m_fe));
      check("cmp_pe",    32'(parity_err), 32'(m_pe));
      check("cmp_busy",  32'(busy),       32'd0);
    end
  end

  function automatic bit par_of(input logic [7:0] d);
    return ^(d & MSK);
  endfunction

  task automatic model_rx(input logic [7:0] d, input bit stop, input bit par);
    logic [7:0] v;
    v = d & MSK;
    if (!stop) begin
      m_fe = 1'b1;
    end else begin
      if (PB != 0 && ((^v) ^ par)) m_pe = 1'b1;
      if (mq.size() >= DEPTH) m_ovr = 1'b1;
      else mq.push_back(v);
    end
  endtask

  task automatic tick(input int gap);
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick(0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input int gap,
                            input int pop_tick, input int max_ticks);
    bit bits [12];
    int nbits;
    int t;
    nbits = 0;
    t = 0;
    chk_en = 1'b0;
    bits[nbits++] = 1'b0;
    for (int k = 0; k < DB; k++) bits[nbits++] = d[k];
    if (PB != 0) bits[nbits++] = par;
    bits[nbits++] = stop;
    for (int b = 0; b < nbits && t < max_ticks; b++) begin
      rxd = bits[b];
      for (int k = 0; k < OS && t < max_ticks; k++) begin
        if (t == pop_tick) rd_en = 1'b1;
        tick(gap);
        rd_en = 1'b0;
        t++;
      end
    end
    if (t < max_ticks) rxd = 1'b1;
  endtask

  task automatic rx_char(input logic [7:0] d, input bit stop, input bit par, input int gap);
    send_frame(d, stop, par, gap, -1, NOLIMIT);
    idle(4);
    model_rx(d, stop, par);
    chk_en = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; sample_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rda", 32'(rda), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({overrun, frame_err, parity_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);
    chk_en = 1'b1;

    // Two back-to-back characters, then show-ahead pop order.
    rx_char(8'hA5, 1'b1, par_of(8'hA5), 0);
    rx_char(8'h3C, 1'b1, par_of(8'h3C), 0);
    check("two_count", 32'(count), 32'd2);
    check("two_head", 32'(rdata), 32'(8'hA5 & MSK));
    pop();
    check("two_next", 32'(rdata), 32'(8'h3C & MSK));
    pop();
    pop();
    check("empty_pop", 32'(count), 32'd0);

    // Short low pulse on the line is rejected as a glitch.
    chk_en = 1'b0;
    rxd = 1'b0;
    repeat (4) tick(0);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    tick(0);
    rxd = 1'b1;
    repeat (10) tick(0);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    chk_en = 1'b1;

    // Overrun: fifth character dropped.
    for (int i = 1; i <= 5; i++) rx_char(8'(i), 1'b1, par_of(8'(i)), 0);
    check("ovr_count", 32'(count), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_head", 32'(rdata), 32'h01);
    repeat (4) pop();
    clr();
    check("ovr_clr", 32'(overrun), 32'd0);

    // Full FIFO with a pop on the push cycle: both happen, no overrun.
    for (int i = 0; i < 4; i++) rx_char(8'h11 + 8'(i), 1'b1, par_of(8'h11 + 8'(i)), 0);
    send_frame(8'h16, 1'b1, par_of(8'h16), 0, PUSH_TICK, NOLIMIT);
    idle(4);
    void'(mq.pop_front());
    model_rx(8'h16, 1'b1, par_of(8'h16));
    chk_en = 1'b1;
    check("simul_count", 32'(count), 32'd4);
    check("simul_ovr", 32'(overrun), 32'd0);
    check("simul_head", 32'(rdata), 32'h12);
    repeat (4) pop();

    // Sparse sample_en (one tick every third clock).
    rx_char(8'h5A, 1'b1, par_of(8'h5A), 2);
    check("gap_data", 32'(rdata), 32'(8'h5A & MSK));
    pop();

    // Stop bit low followed by a held-low line: exactly one framing error.
    send_frame(8'h55, 1'b0, par_of(8'h55), 0, -1, NOLIMIT);
    rxd = 1'b0;
    repeat (20) tick(0);
    model_rx(8'h55, 1'b0, par_of(8'h55));
    check("brk_fe", 32'(frame_err), 32'd1);
    check("brk_nostore", 32'(count), 32'd0);
    clr();
    repeat (20) tick(0);
    check("brk_fe_once", 32'(frame_err), 32'd0);
    check("brk_busy", 32'(busy), 32'd1);
    idle(4);
    chk_en = 1'b1;
    rx_char(8'h66, 1'b1, par_of(8'h66), 0);
    check("brk_next", 32'(rdata), 32'(8'h66 & MSK));

`ifdef SPART_RX_PARITY_EN
    rx_char(8'h41, 1'b1, 1'b1, 0);
    check("par_err", 32'(parity_err), 32'd1);
    check("par_stored", 32'(count), 32'd2);
    clr();
    rx_char(8'h41, 1'b1, 1'b0, 0);
    check("par_ok", 32'(parity_err), 32'd0);
    check("par_count", 32'(count), 32'd3);
`endif

    // Reset in the middle of data bit 4.
    send_frame(8'h0F, 1'b1, par_of(8'h0F), 0, -1, OS * 5 + OS / 2);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rda", 32'(rda), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_flags", 32'({overrun, frame_err, parity_err}), 32'd0);
    mq.delete();
    m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b1;
    rst = 1'b1;
    idle(4);
    chk_en = 1'b1;
    rx_char(8'h0F, 1'b1, par_of(8'h0F), 0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data", 32'(rdata), 32'h0F);
    pop();
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
